// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: the most recent winner drops to lowest priority.
// One cycle of latency from req to grant; there is no handshake, so every cycle is re-arbitrated.
module round_robin_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_an,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  localparam int              IDX_W   = ID_W + 1;
  localparam logic [IDX_W-1:0] N_IDX   = IDX_W'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               vld_q, vld_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [IDX_W-1:0]   scan_idx;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;

  // Cyclic scan from ptr; one extra index bit keeps ptr+k from overflowing before the wrap.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + IDX_W'(k);
      if (scan_idx >= N_IDX) begin
        scan_idx = scan_idx - N_IDX;
      end
      if (!win_vld && req[scan_idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = '0;
    vld_d   = 1'b0;
    id_d    = '0;
    if (win_vld) begin
      grant_d[win_id] = 1'b1;
      vld_d           = 1'b1;
      id_d            = win_id;
      ptr_d           = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_an) begin
    if (rst_an) begin
      ptr_q   <= '0;
      grant_q <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = vld_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: a 2-requester and a 4-requester instance share clock and reset.
module tb_round_robin_arbiter;

  logic       clk = 1'b0;
  logic       rst_an = 1'b1;
  logic [1:0] req2 = 2'b00;
  logic [3:0] req4 = 4'b0000;
  logic [1:0] grant2;
  logic       vld2;
  logic [0:0] id2;
  logic [3:0] grant4;
  logic       vld4;
  logic [1:0] id4;

  int total = 0;
  int bad   = 0;

  round_robin_arbiter #(.NUM_REQ(2)) dut2 (
    .clk(clk), .rst_an(rst_an), .req(req2),
    .grant(grant2), .grant_valid(vld2), .grant_id(id2)
  );

  round_robin_arbiter #(.NUM_REQ(4)) dut4 (
    .clk(clk), .rst_an(rst_an), .req(req4),
    .grant(grant4), .grant_valid(vld4), .grant_id(id4)
  );

  always #5 clk = ~clk;

  // Structural invariants checked on every falling edge.
  always @(negedge clk) begin
    total++;
    if (!$onehot0(grant2) || (vld2 !== |grant2)) begin
      bad++;
      $display("FAIL onehot2: grant=%b valid=%b, need one-hot/zero with valid=OR", grant2, vld2);
    end
    total++;
    if (!$onehot0(grant4) || (vld4 !== |grant4)) begin
      bad++;
      $display("FAIL onehot4: grant=%b valid=%b, need one-hot/zero with valid=OR", grant4, vld4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_an = 1'b1;
    #2;
    total++;
    if ({grant2, vld2, id2} !== 4'b0 || {grant4, vld4, id4} !== 7'b0) begin
      bad++;
      $display("FAIL %s: got g2=%b v2=%b id2=%0d g4=%b v4=%b id4=%0d, need all zero",
               tag, grant2, vld2, id2, grant4, vld4, id4);
    end
    rst_an = 1'b0;
  endtask

  task automatic test_reset();
    req2 = 2'b11;
    req4 = 4'b1111;
    #2;
    total++;
    if ({grant2, vld2, id2} !== 4'b0 || {grant4, vld4, id4} !== 7'b0) begin
      bad++;
      $display("FAIL reset_hold: got g2=%b v2=%b id2=%0d g4=%b, need zeros", grant2, vld2, id2, grant4);
    end
    tick();
    rst_an = 1'b0;
    tick();
    total++;
    if (grant2 !== 2'b01 || vld2 !== 1'b1 || id2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant: got g=%b v=%b id=%0d, need g=01 v=1 id=0", grant2, vld2, id2);
    end
    total++;
    if (grant4 !== 4'b0001 || id4 !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_grant4: got g=%b id=%0d, need 0001 id=0", grant4, id4);
    end
  endtask

  task automatic test_single();
    do_reset("reset_single");
    req2 = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (grant2 !== 2'b01 || id2 !== 1'b0 || vld2 !== 1'b1) begin
        bad++;
        $display("FAIL single[%0d]: got g=%b id=%0d v=%b, need 01 id=0 v=1", i, grant2, id2, vld2);
      end
    end
    req2 = 2'b11;
    tick();
    total++;
    if (grant2 !== 2'b10 || id2 !== 1'b1) begin
      bad++;
      $display("FAIL single_ptr: got g=%b id=%0d, need 10 id=1", grant2, id2);
    end
  endtask

  task automatic test_contention();
    logic [1:0] rq [6] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
    logic [1:0] ex [6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    do_reset("reset_contention");
    for (int i = 0; i < 6; i++) begin
      req2 = rq[i];
      tick();
      total++;
      if (grant2 !== ex[i] || id2 !== ex[i][1]) begin
        bad++;
        $display("FAIL contention[%0d]: got g=%b id=%0d, need g=%b id=%0d", i, grant2, id2, ex[i], ex[i][1]);
      end
    end
  endtask

  task automatic test_continuous();
    do_reset("reset_continuous");
    req2 = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (grant2 !== ((i % 2 == 0) ? 2'b01 : 2'b10) || id2 !== 1'(i % 2)) begin
        bad++;
        $display("FAIL continuous2[%0d]: got g=%b id=%0d, need id=%0d", i, grant2, id2, i % 2);
      end
    end
    req2 = 2'b00;
    do_reset("reset_continuous4");
    req4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (grant4 !== (4'b0001 << (i % 4)) || id4 !== 2'(i % 4)) begin
        bad++;
        $display("FAIL continuous4[%0d]: got g=%b id=%0d, need g=%b id=%0d",
                 i, grant4, id4, 4'b0001 << (i % 4), i % 4);
      end
    end
    req4 = 4'b0000;
  endtask

  task automatic test_idle();
    do_reset("reset_idle");
    req2 = 2'b01;
    tick();
    req2 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (grant2 !== 2'b00 || vld2 !== 1'b0 || id2 !== 1'b0) begin
        bad++;
        $display("FAIL idle[%0d]: got g=%b v=%b id=%0d, need 00 v=0 id=0", i, grant2, vld2, id2);
      end
    end
    req2 = 2'b11;
    tick();
    total++;
    if (grant2 !== 2'b10 || vld2 !== 1'b1 || id2 !== 1'b1) begin
      bad++;
      $display("FAIL idle_ptr_kept: got g=%b v=%b id=%0d, need 10 v=1 id=1", grant2, vld2, id2);
    end
  endtask

  task automatic test_sparse4();
    do_reset("reset_sparse");
    req4 = 4'b0010;
    tick();
    total++;
    if (grant4 !== 4'b0010 || id4 !== 2'd1) begin
      bad++;
      $display("FAIL sparse_setup: got g=%b id=%0d, need 0010 id=1", grant4, id4);
    end
    req4 = 4'b0011;
    tick();
    total++;
    if (grant4 !== 4'b0001 || id4 !== 2'd0 || vld4 !== 1'b1) begin
      bad++;
      $display("FAIL sparse_wrap: got g=%b id=%0d v=%b, need 0001 id=0 v=1", grant4, id4, vld4);
    end
    req4 = 4'b1111;
    tick();
    total++;
    if (grant4 !== 4'b0010 || id4 !== 2'd1) begin
      bad++;
      $display("FAIL sparse_ptr: got g=%b id=%0d, need 0010 id=1", grant4, id4);
    end
    req4 = 4'b1000;
    tick();
    req4 = 4'b1001;
    tick();
    total++;
    if (grant4 !== 4'b0001 || id4 !== 2'd0) begin
      bad++;
      $display("FAIL last_wraps_ptr: got g=%b id=%0d, need 0001 id=0", grant4, id4);
    end
    req4 = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset("reset_mid_pre");
    req2 = 2'b11;
    tick();
    tick();
    total++;
    if (grant2 !== 2'b10) begin
      bad++;
      $display("FAIL mid_pre: got g=%b, need 10", grant2);
    end
    do_reset("reset_mid_async");
    tick();
    total++;
    if (grant2 !== 2'b01 || id2 !== 1'b0) begin
      bad++;
      $display("FAIL mid_after_release: got g=%b id=%0d, need 01 id=0", grant2, id2);
    end
    req2 = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_continuous();
    test_idle();
    test_sparse4();
    test_reset_mid();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
